iter_muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide coprocessor for the multicycle core datapath. It replaces single-cycle multiply with a shared radix-2 shift-add/restoring engine. Supported ops: MUL/MLA, long multiply (signed/unsigned, with or without accumulate), and UDIV/SDIV. The controller starts it with a start/busy/done handshake and writes result_lo/result_hi back through the regfile ports.

---
 rtl/iter_muldiv_unit.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
// ---------------------------------------------------------------------------
// iter_muldiv_unit
//
// Iterative radix-2 multiply/divide coprocessor. A single shared shift-add /
// restoring-divide engine runs every operation in a fixed WIDTH+1 cycles.
// Signed operations run on operand magnitudes, and the sign is fixed up in
// the final FIX cycle.
//
// Ports
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   start        request, accepted only while busy=0
//   op[2:0]      000 MUL, 001 MLA, 010 UDIV, 011 SDIV,
//                100 UMULL, 101 UMLAL, 110 SMULL, 111 SMLAL
//   a            multiplicand / dividend
//   b            multiplier / divisor
//   acc_lo       accumulate low word  (MLA, UMLAL, SMLAL)
//   acc_hi       accumulate high word (UMLAL, SMLAL)
//   busy         operation in flight
//   done         one-cycle pulse, results valid
//   result_lo    product low / quotient
//   result_hi    product high / remainder (zero for MUL/MLA)
//   flag_n       MSB of result (hi for long ops, lo otherwise)
//   flag_z       result zero (full 2*WIDTH for long ops, lo otherwise)
//   div_by_zero  set with done when a divide had b==0
//   dbg_state    current FSM state (0 IDLE, 1 RUN, 2 FIX)
//
// Handshake: a rising edge that sees start=1 while the unit is IDLE captures
// op/a/b/acc_lo/acc_hi. busy is high from the next cycle until the FIX edge.
// done pulses high for exactly one cycle after FIX, with busy low in that
// cycle, so start may be asserted in the done cycle to chain operations.
// start is ignored while busy=1. Inputs are sampled only at capture.
// Every output comes directly from a register.
// ---------------------------------------------------------------------------
module iter_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z,
  output logic             div_by_zero,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  // Captured operation.
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;        // raw dividend, returned on divide-by-zero
  logic [WIDTH-1:0] r_ma;       // |a| (or a for unsigned ops)
  logic [WIDTH-1:0] r_mb;       // |b| (or b for unsigned ops)
  logic             r_neg_q;    // product / quotient must be negated
  logic             r_neg_r;    // remainder must be negated (dividend sign)
  logic [WIDTH-1:0] r_acc_lo;
  logic [WIDTH-1:0] r_acc_hi;
  logic [CNT_W-1:0] r_cnt;

  // Working registers.
  // Multiply: {r_hi, r_lo} is the 2*WIDTH partial product; r_lo starts as
  //           the multiplier and is consumed LSB-first as product bits
  //           shift in from the top.
  // Divide:   r_hi is the partial remainder, r_lo starts as the dividend and
  //           fills with quotient bits from the bottom.
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Output registers.
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_res_lo;
  logic [WIDTH-1:0] r_res_hi;
  logic             r_flag_n;
  logic             r_flag_z;
  logic             r_dbz;

  // -------------------------------------------------------------------------
  // Capture-side decode (operates on the live inputs)
  // -------------------------------------------------------------------------
  logic             w_in_is_div;
  logic             w_in_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;

  assign w_in_is_div = (op[2:1] == 2'b01);
  // SDIV (011), SMULL (110) and SMLAL (111) treat operands as signed.
  assign w_in_signed = (op == 3'b011) || (op[2:1] == 2'b11);
  assign w_a_neg     = w_in_signed & a[WIDTH-1];
  assign w_b_neg     = w_in_signed & b[WIDTH-1];
  // The most-negative value maps onto itself, which as an unsigned
  // magnitude is exactly 2^(WIDTH-1), so no special case is needed here.
  assign w_a_mag     = w_a_neg ? -a : a;
  assign w_b_mag     = w_b_neg ? -b : b;

  // -------------------------------------------------------------------------
  // Iteration datapath
  // -------------------------------------------------------------------------
  logic             w_run_is_div;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;

  assign w_run_is_div = (r_op[2:1] == 2'b01);

  // Shift-add: add the multiplicand when the current multiplier bit is set,
  // then shift the carry/sum right by one into the 2*WIDTH product.
  assign w_mul_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_ma} : '0);

  // Restoring divide: shift the next dividend bit into the remainder and
  // subtract the divisor only if it fits. When it fits, the difference is
  // below the divisor, so the low WIDTH bits are the whole result.
  assign w_div_shift = {r_hi, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_mb});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_mb;

  // -------------------------------------------------------------------------
  // FIX-cycle result formation
  // -------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_prod_sgn;
  logic [2*WIDTH-1:0] w_prod_acc;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_is_sdiv;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic               w_res_dbz;
  logic               w_res_n;
  logic               w_res_z;

  assign w_is_sdiv  = (r_op == 3'b011);
  assign w_prod     = {r_hi, r_lo};
  // Only SMULL/SMLAL carry a sign; MUL/MLA keep just the low word, which is
  // identical for signed and unsigned operands.
  assign w_prod_sgn = (r_op[2] & r_op[1] & r_neg_q) ? -w_prod : w_prod;
  // op[0] selects the accumulating form of every multiply. Accumulation is
  // modulo 2^(2*WIDTH); MLA only keeps the low word, so acc_hi never
  // reaches its result.
  assign w_prod_acc = w_prod_sgn + (r_op[0] ? {r_acc_hi, r_acc_lo} : '0);
  // Quotient truncates toward zero; the remainder follows the dividend.
  // For most-negative / -1 the magnitude quotient is 2^(WIDTH-1) with no
  // negation, which is already the wrapped result a with remainder 0.
  assign w_quo      = (w_is_sdiv & r_neg_q) ? -r_lo : r_lo;
  assign w_rem      = (w_is_sdiv & r_neg_r) ? -r_hi : r_hi;

  always_comb begin
    w_res_lo  = '0;
    w_res_hi  = '0;
    w_res_dbz = 1'b0;
    w_res_n   = 1'b0;
    w_res_z   = 1'b0;

    if (w_run_is_div) begin
      if (r_mb == '0) begin
        w_res_lo  = '0;
        w_res_hi  = r_a;
        w_res_dbz = 1'b1;
      end else begin
        w_res_lo  = w_quo;
        w_res_hi  = w_rem;
      end
    end else if (r_op[2]) begin
      w_res_lo = w_prod_acc[WIDTH-1:0];
      w_res_hi = w_prod_acc[2*WIDTH-1:WIDTH];
    end else begin
      w_res_lo = w_prod_acc[WIDTH-1:0];
      w_res_hi = '0;
    end

    if (r_op[2]) begin
      w_res_n = w_res_hi[WIDTH-1];
      w_res_z = ({w_res_hi, w_res_lo} == '0);
    end else begin
      w_res_n = w_res_lo[WIDTH-1];
      w_res_z = (w_res_lo == '0);
    end
  end

  // -------------------------------------------------------------------------
  // FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next_state = ST_RUN;
      ST_RUN:  if (r_cnt == LAST_ITER) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op     <= '0;
      r_a      <= '0;
      r_ma     <= '0;
      r_mb     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_acc_lo <= '0;
      r_acc_hi <= '0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_flag_n <= 1'b0;
      r_flag_z <= 1'b0;
      r_dbz    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_a      <= a;
            r_ma     <= w_a_mag;
            r_mb     <= w_b_mag;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_acc_lo <= acc_lo;
            r_acc_hi <= acc_hi;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= w_in_is_div ? w_a_mag : w_b_mag;
            r_busy   <= 1'b1;
            r_dbz    <= 1'b0;
          end
        end

        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_run_is_div) begin
            r_hi <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            r_lo <= {r_lo[WIDTH-2:0], w_div_ge};
          end else begin
            r_hi <= w_mul_sum[WIDTH:1];
            r_lo <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
          end
        end

        ST_FIX: begin
          r_res_lo <= w_res_lo;
          r_res_hi <= w_res_hi;
          r_flag_n <= w_res_n;
          r_flag_z <= w_res_z;
          r_dbz    <= w_res_dbz;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end

        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign result_lo   = r_res_lo;
  assign result_hi   = r_res_hi;
  assign flag_n      = r_flag_n;
  assign flag_z      = r_flag_z;
  assign div_by_zero = r_dbz;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_iter_muldiv_unit
//
// Directed-vector bench for iter_muldiv_unit: a WIDTH=32 instance exercises
// every op class, special cases, back-to-back issue, ignored start and reset
// abort; a WIDTH=8 instance checks the shorter latency.
// ---------------------------------------------------------------------------
module tb_iter_muldiv_unit;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] a = '0, b = '0, acc_lo = '0, acc_hi = '0;
  logic        busy, done, flag_n, flag_z, div_by_zero;
  logic [31:0] result_lo, result_hi;
  logic [1:0]  dbg_state;

  iter_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .acc_lo(acc_lo), .acc_hi(acc_hi), .busy(busy), .done(done),
    .result_lo(result_lo), .result_hi(result_hi), .flag_n(flag_n),
    .flag_z(flag_z), .div_by_zero(div_by_zero), .dbg_state(dbg_state)
  );

  // 8-bit instance
  logic       start8 = 1'b0;
  logic [2:0] op8 = '0;
  logic [7:0] a8 = '0, b8 = '0, acc8_lo = '0, acc8_hi = '0;
  logic       busy8, done8, flag8_n, flag8_z, dbz8;
  logic [7:0] res8_lo, res8_hi;
  logic [1:0] dbg8_state;

  iter_muldiv_unit #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .acc_lo(acc8_lo), .acc_hi(acc8_hi), .busy(busy8), .done(done8),
    .result_lo(res8_lo), .result_hi(res8_hi), .flag_n(flag8_n),
    .flag_z(flag8_z), .div_by_zero(dbz8), .dbg_state(dbg8_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pops the expected {hi, lo} pushed by the caller and compares the result.
  task automatic check_result(input string tag);
    logic [63:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_expq_empty"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_lo"}, {32'd0, result_lo}, {32'd0, e[31:0]});
      check({tag, "_hi"}, {32'd0, result_hi}, {32'd0, e[63:32]});
    end
  endtask

  // -------------------------------------------------------------------------
  // Driver: call at a negedge. Issues one op and returns at the negedge of
  // the done cycle. lat counts rising edges after capture until done is seen;
  // busy_cnt counts sampled cycles with busy high. At iteration poke a junk
  // start with different operands is presented while the unit is busy.
  // -------------------------------------------------------------------------
  task automatic run_op(input logic [2:0] t_op, input logic [31:0] t_a,
                        input logic [31:0] t_b, input logic [31:0] t_lo,
                        input logic [31:0] t_hi, input int poke,
                        output int lat, output int busy_cnt);
    int k;
    op = t_op; a = t_a; b = t_b; acc_lo = t_lo; acc_hi = t_hi;
    start = 1'b1;
    @(negedge clk);
    k = 0;
    busy_cnt = 0;
    while (k < 100) begin
      start = (k == poke);
      if (k == poke) begin
        op = 3'b010; a = 32'd0; b = 32'd0; acc_lo = 32'hFFFF_FFFF;
      end
      if (done) break;
      if (busy) busy_cnt++;
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    if (k >= 100) check("done_timeout", 64'(k), 64'd33);
    lat = k;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  int lat, bcnt, dcnt, k8;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_flags", {61'd0, flag_n, flag_z, div_by_zero}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MUL 7*6, with latency, busy length and single-cycle done
    exp_q.push_back({32'd0, 32'd42});
    run_op(3'b000, 32'd7, 32'd6, 32'd0, 32'd0, -1, lat, bcnt);
    check("mul_lat", 64'(lat), 64'd33);
    check("mul_busy_cycles", 64'(bcnt), 64'd33);
    check("mul_busy_in_done", 64'(busy), 64'd0);
    check_result("mul");
    check("mul_z", 64'(flag_z), 64'd0);
    @(negedge clk);
    check("mul_done_one_cycle", 64'(done), 64'd0);
    check("mul_hold_lo", 64'(result_lo), 64'd42);

    // SMULL -3*5
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFF1);
    run_op(3'b110, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, -1, lat, bcnt);
    check_result("smull");
    check("smull_n", 64'(flag_n), 64'd1);

    // UMLAL 0xFFFFFFFF^2 + 1
    exp_q.push_back(64'hFFFF_FFFE_0000_0002);
    run_op(3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, -1, lat, bcnt);
    check_result("umlal");

    // SDIV -7/2
    exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_op(3'b011, 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, -1, lat, bcnt);
    check_result("sdiv_neg");

    // UDIV 5/0
    exp_q.push_back({32'd5, 32'd0});
    run_op(3'b010, 32'd5, 32'd0, 32'd0, 32'd0, -1, lat, bcnt);
    check_result("udiv_dbz");
    check("udiv_dbz_flag", 64'(div_by_zero), 64'd1);
    check("udiv_dbz_z", 64'(flag_z), 64'd1);
    check("udiv_dbz_lat", 64'(lat), 64'd33);

    // SDIV overflow: most-negative / -1
    exp_q.push_back({32'd0, 32'h8000_0000});
    run_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, -1, lat, bcnt);
    check_result("sdiv_ovf");
    check("sdiv_ovf_dbz", 64'(div_by_zero), 64'd0);
    check("sdiv_ovf_n", 64'(flag_n), 64'd1);

    // MLA 3*4+10, acc_hi must not leak into the result
    exp_q.push_back({32'd0, 32'd22});
    run_op(3'b001, 32'd3, 32'd4, 32'd10, 32'h0000_DEAD, -1, lat, bcnt);
    check_result("mla");

    // SMLAL -2*3 + 10
    exp_q.push_back({32'd0, 32'd4});
    run_op(3'b111, 32'hFFFF_FFFE, 32'd3, 32'd10, 32'd0, -1, lat, bcnt);
    check_result("smlal");
    check("smlal_n", 64'(flag_n), 64'd0);

    // UDIV 100/7
    exp_q.push_back({32'd2, 32'd14});
    run_op(3'b010, 32'd100, 32'd7, 32'd0, 32'd0, -1, lat, bcnt);
    check_result("udiv");

    // SDIV 7/-2
    exp_q.push_back({32'd1, 32'hFFFF_FFFD});
    run_op(3'b011, 32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, -1, lat, bcnt);
    check_result("sdiv_negb");

    // Back-to-back: start presented in the done cycle
    exp_q.push_back({32'd1, 32'd0});
    run_op(3'b100, 32'h0001_0000, 32'h0001_0000, 32'd0, 32'd0, -1, lat, bcnt);
    check("b2b_lat", 64'(lat), 64'd33);
    check_result("b2b_umull");
    check("b2b_z", 64'(flag_z), 64'd0);

    // start mid-RUN with changed operands is ignored
    exp_q.push_back({32'd0, 32'd143});
    run_op(3'b000, 32'd11, 32'd13, 32'd0, 32'd0, 10, lat, bcnt);
    check("poke_lat", 64'(lat), 64'd33);
    check_result("poke_mul");
    @(negedge clk);
    check("poke_no_restart", 64'(busy), 64'd0);

    // Reset asserted asynchronously at iteration 10
    op = 3'b000; a = 32'h1234; b = 32'h5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    check("abort_state_run", 64'(dbg_state), 64'd1);
    reset = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_lo", 64'(result_lo), 64'd0);
    check("abort_hi", 64'(result_hi), 64'd0);
    check("abort_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_no_done", 64'(dcnt), 64'd0);

    exp_q.push_back({32'd0, 32'd9});
    run_op(3'b000, 32'd3, 32'd3, 32'd0, 32'd0, -1, lat, bcnt);
    check_result("post_abort_mul");

    // WIDTH=8: UMULL 0xFF*0xFF
    @(negedge clk);
    op8 = 3'b100; a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    k8 = 0;
    while (!done8 && k8 < 50) begin
      @(negedge clk);
      k8++;
    end
    check("w8_lat", 64'(k8), 64'd9);
    check("w8_hi", 64'(res8_hi), 64'hFE);
    check("w8_lo", 64'(res8_lo), 64'h01);
    check("w8_n", 64'(flag8_n), 64'd1);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
